psram_arbiter: RTL and testbench

Two-requester arbiter that shares the single PSRAM controller port (`oe`/`wr`/`address`/`data_in`/`data_out`/`busy`) between the HDMI scan-out fetch and a host read/write port. The video side issues address-incrementing read bursts that fill a line buffer. The host side issues single-word accesses. The arbiter sequences one controller command at a time and routes read data back to the owner. It sits between the pixel-clock domain logic and the PSRAM controller wrapper, clocked by the controller clock.

---
 rtl/psram_pkg.sv | 9 +
 rtl/psram_burst_ctr.sv | 32 +++
 rtl/psram_arbiter.sv | 116 +++++++++++
 tb/tb_psram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: shared FSM state type, default widths and owner encoding for the PSRAM arbiter
package psram_pkg;
  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 9;
  localparam logic PRIO_VID  = 1'b0;
  localparam logic PRIO_HOST = 1'b1;
  typedef enum logic [2:0] {IDLE, V_ISSUE, V_WAIT, H_ISSUE, H_WAIT} arb_state_t;
endpackage

// File: rtl/psram_burst_ctr.sv
// psram_burst_ctr: video burst word-address incrementer and remaining-word counter
// Ports: i_load latches i_addr/i_len (len 0 counts as 1); i_step advances one word;
//        o_addr is the current word address; o_last flags the final word of the burst.
module psram_burst_ctr #(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 9
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_rem  <= (i_len == '0) ? LEN_W'(1) : i_len;
    end else if (i_step) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_rem  <= r_rem - LEN_W'(1);
    end
  assign o_addr = r_addr;
  assign o_last = r_rem == LEN_W'(1);
endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PSRAM controller port between video read bursts and host single-word accesses
// Ports: vid_* burst request/grant and returned words; host_* single access request/ack;
//        mem_* controller command port (oe/wr pulses, addr/wdata held until completion, rdata, busy).
// Build option: PSRAM_ARB_RR_EN selects transaction round-robin; otherwise video has fixed priority.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [LEN_W-1:0]  vid_len,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_oe,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy
);
  arb_state_t        r_state, w_next;
  logic              r_seen, r_last, r_h_we;
  logic [ADDR_W-1:0] r_h_addr, w_ctr_addr;
  logic [DATA_W-1:0] r_wdata, r_vid_rdata, r_host_rdata;
  logic              w_pick_vid, w_gnt_h, w_cmp, w_last, w_v_cmp, w_h_cmp;

`ifdef PSRAM_ARB_RR_EN
  assign w_pick_vid = vid_req && (!host_req || r_last == PRIO_HOST);
`else
  assign w_pick_vid = vid_req;
`endif

  assign vid_gnt    = r_state == IDLE && w_pick_vid;
  assign w_gnt_h    = r_state == IDLE && !w_pick_vid && host_req;
  // A command is finished only once busy has been seen high and then low again.
  assign w_cmp      = r_seen && !mem_busy;
  assign w_v_cmp    = r_state == V_WAIT && w_cmp;
  assign w_h_cmp    = r_state == H_WAIT && w_cmp;
  assign vid_rvalid = w_v_cmp;
  assign vid_done   = w_v_cmp && w_last;
  assign host_ack   = w_h_cmp;
  // Completion-cycle bypass so the data is valid alongside the pulse, then held.
  assign vid_rdata  = w_v_cmp ? mem_rdata : r_vid_rdata;
  assign host_rdata = (w_h_cmp && !r_h_we) ? mem_rdata : r_host_rdata;
  assign mem_addr   = (r_last == PRIO_HOST) ? r_h_addr : w_ctr_addr;
  assign mem_wdata  = r_wdata;

  psram_burst_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_load (vid_gnt),
    .i_step (w_v_cmp),
    .i_addr (vid_addr),
    .i_len  (vid_len),
    .o_addr (w_ctr_addr),
    .o_last (w_last)
  );

  always_comb begin
    w_next = r_state;
    mem_oe = 1'b0;
    mem_wr = 1'b0;
    case (r_state)
      IDLE:    w_next = w_pick_vid ? V_ISSUE : host_req ? H_ISSUE : IDLE;
      V_ISSUE: begin
        mem_oe = !mem_busy;
        w_next = mem_busy ? V_ISSUE : V_WAIT;
      end
      V_WAIT:  w_next = !w_cmp ? V_WAIT : w_last ? IDLE : V_ISSUE;
      H_ISSUE: begin
        mem_oe = !mem_busy && !r_h_we;
        mem_wr = !mem_busy && r_h_we;
        w_next = mem_busy ? H_ISSUE : H_WAIT;
      end
      H_WAIT:  w_next = w_cmp ? IDLE : H_WAIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_seen       <= 1'b0;
      r_last       <= PRIO_VID;
      r_h_we       <= 1'b0;
      r_h_addr     <= '0;
      r_wdata      <= '0;
      r_vid_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_seen  <= (r_state == V_WAIT || r_state == H_WAIT) && (r_seen || mem_busy);
      if (vid_gnt) r_last <= PRIO_VID;
      if (w_gnt_h) begin
        r_last   <= PRIO_HOST;
        r_h_we   <= host_we;
        r_h_addr <= host_addr;
        r_wdata  <= host_wdata;
      end
      if (w_v_cmp) r_vid_rdata <= mem_rdata;
      if (w_h_cmp && !r_h_we) r_host_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: scoreboard bench for psram_arbiter with a behavioural PSRAM controller model
module tb_psram_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        vid_req = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [21:0] vid_addr = '0, host_addr = '0;
  logic [8:0]  vid_len = '0;
  logic [15:0] host_wdata = '0;
  logic        vid_gnt, vid_rvalid, vid_done, host_ack, mem_oe, mem_wr, mem_busy;
  logic [15:0] vid_rdata, host_rdata, mem_wdata, mem_rdata;
  logic [21:0] mem_addr;

  always #5 clk = ~clk;

  psram_arbiter dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_len(vid_len), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata), .vid_done(vid_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_oe(mem_oe), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  int checks = 0, failures = 0;

  // Controller model: busy for lat cycles starting the cycle after a command.
  int          lat = 1, cnt = 0;
  logic        ext_busy = 1'b0;
  logic [15:0] rd = '0;
  logic [15:0] mem [logic [21:0]];
  function automatic logic [15:0] fn(input logic [21:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction
  assign mem_busy  = (cnt != 0) || ext_busy;
  assign mem_rdata = rd;
  always @(posedge clk)
    if (mem_oe || mem_wr) begin
      cnt <= lat;
      if (mem_wr) mem[mem_addr] = mem_wdata;
      else rd <= mem.exists(mem_addr) ? mem[mem_addr] : fn(mem_addr);
    end else if (cnt != 0) cnt <= cnt - 1;

  typedef struct packed {logic wr; logic [21:0] a; logic [15:0] d;} cmd_t;
  typedef struct packed {logic [15:0] d; logic done;} vexp_t;
  typedef struct packed {logic we; logic [15:0] d;} hexp_t;
  cmd_t  cq[$];
  vexp_t vq[$];
  hexp_t hq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  always @(negedge clk) begin
    cmd_t e; vexp_t v; hexp_t h;
    if (mem_oe || mem_wr) begin
      check("cmd_while_busy", 64'(mem_busy), 64'(0));
      if (cq.size() == 0) fail("unexpected_cmd");
      else begin
        e = cq.pop_front();
        check("cmd_wr", 64'(mem_wr), 64'(e.wr));
        check("cmd_oe", 64'(mem_oe), 64'(!e.wr));
        check("cmd_addr", 64'(mem_addr), 64'(e.a));
        if (e.wr) check("cmd_wdata", 64'(mem_wdata), 64'(e.d));
      end
    end
    if (vid_rvalid) begin
      if (vq.size() == 0) fail("unexpected_vid_rvalid");
      else begin
        v = vq.pop_front();
        check("vid_rdata", 64'(vid_rdata), 64'(v.d));
        check("vid_done", 64'(vid_done), 64'(v.done));
      end
    end else if (vid_done) fail("vid_done_without_rvalid");
    if (host_ack) begin
      if (hq.size() == 0) fail("unexpected_host_ack");
      else begin
        h = hq.pop_front();
        if (!h.we) check("host_rdata", 64'(host_rdata), 64'(h.d));
      end
    end
  end

  task automatic exp_v(input logic [21:0] a, input logic last);
    cq.push_back('{1'b0, a, 16'h0});
    vq.push_back('{fn(a), last});
  endtask

  task automatic exp_vb(input logic [21:0] a, input int n);
    for (int i = 0; i < n; i++) exp_v(a + 22'(i), i == n - 1);
  endtask

  task automatic exp_h(input logic we, input logic [21:0] a, input logic [15:0] d);
    cq.push_back('{we, a, d});
    hq.push_back('{we, d});
  endtask

  task automatic vid_go(input logic [21:0] a, input logic [8:0] n);
    int k;
    vid_addr = a; vid_len = n; vid_req = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (vid_gnt) break;
    end
    if (k == 300) fail("vid_gnt_timeout");
    @(posedge clk); #1 vid_req = 1'b0;
  endtask

  task automatic host_do(input logic we, input logic [21:0] a, input logic [15:0] d);
    int k;
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (host_ack) break;
    end
    if (k == 300) fail("host_ack_timeout");
    @(posedge clk); #1 host_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 500; k++) begin
      if (cq.size() == 0 && vq.size() == 0 && hq.size() == 0) break;
      @(posedge clk); #1;
    end
    check({tag, "_cmds_left"}, 64'(cq.size()), 64'(0));
    check({tag, "_vid_left"}, 64'(vq.size()), 64'(0));
    check({tag, "_host_left"}, 64'(hq.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_pulses"}, 64'({vid_gnt, vid_rvalid, vid_done, host_ack, mem_oe, mem_wr}), 64'(0));
    check({tag, "_vid_rdata"}, 64'(vid_rdata), 64'(0));
    check({tag, "_host_rdata"}, 64'(host_rdata), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int k;
    #12 chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Host write then read back.
    exp_h(1'b1, 22'h000123, 16'hA5C3);
    host_do(1'b1, 22'h000123, 16'hA5C3);
    exp_h(1'b0, 22'h000123, 16'hA5C3);
    host_do(1'b0, 22'h000123, 16'h0000);
    drain("host_wr_rd");

    // Burst wrapping the top of the address space.
    exp_v(22'h3FFFFE, 1'b0);
    exp_v(22'h3FFFFF, 1'b0);
    exp_v(22'h000000, 1'b0);
    exp_v(22'h000001, 1'b1);
    vid_go(22'h3FFFFE, 9'd4);
    drain("vid_wrap");

    // Simultaneous requests; last owner is video.
`ifdef PSRAM_ARB_RR_EN
    exp_h(1'b0, 22'h000123, 16'hA5C3);
    exp_vb(22'h000040, 2);
`else
    exp_vb(22'h000040, 2);
    exp_h(1'b0, 22'h000123, 16'hA5C3);
`endif
    fork
      vid_go(22'h000040, 9'd2);
      host_do(1'b0, 22'h000123, 16'h0000);
    join
    drain("contention");

    // Host request raised mid-burst waits for the whole burst.
    exp_vb(22'h000400, 8);
    exp_h(1'b1, 22'h000500, 16'h0F0F);
    vid_go(22'h000400, 9'd8);
    repeat (4) @(posedge clk);
    #1 host_do(1'b1, 22'h000500, 16'h0F0F);
    drain("mid_burst");

    // Length 0 behaves as a single word.
    exp_vb(22'h000055, 1);
    vid_go(22'h000055, 9'd0);
    drain("len_zero");

    // Controller busy before issue: exactly one command once busy drops.
    ext_busy = 1'b1;
    exp_h(1'b1, 22'h000200, 16'h1234);
    fork
      begin
        repeat (10) @(posedge clk);
        #1 ext_busy = 1'b0;
      end
      host_do(1'b1, 22'h000200, 16'h1234);
    join
    exp_h(1'b0, 22'h000200, 16'h1234);
    host_do(1'b0, 22'h000200, 16'h0000);
    drain("busy_hold");

    // Reset during V_WAIT abandons the burst.
    lat = 4;
    exp_vb(22'h000100, 4);
    vid_go(22'h000100, 9'd4);
    for (k = 0; k < 50; k++) begin
      if (mem_oe) break;
      @(negedge clk);
    end
    if (k == 50) fail("first_oe_timeout");
    @(posedge clk); #1 rst = 1'b1;
    cq.delete(); vq.delete(); hq.delete();
    #1 chk_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lat = 1;
    repeat (20) @(posedge clk);
    #1;
    exp_vb(22'h002000, 2);
    vid_go(22'h002000, 9'd2);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
